asrv32_mem_arbiter: RTL and testbench
=====================================

ASRV32_MEM_ARBITER -- requirements
Module: asrv32_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width of all ports, passed through unmodified.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_dbg_req  input  1  debug/loader port request, held until o_dbg_ack.
REQ-005 i_dbg_addr  input  ADDR_WIDTH  debug byte address.
REQ-006 i_dbg_wdata  input  32  debug write data.
REQ-007 i_dbg_wr_en  input  1  debug access is write (1) or read (0).
REQ-008 i_dbg_wr_mask  input  4  debug byte-enable mask.
REQ-009 o_dbg_ack  output  1  one-cycle completion pulse, debug port.
REQ-010 i_d_req, i_d_addr, i_d_wdata, i_d_wr_en, i_d_wr_mask, o_d_ack  same directions/widths/meanings as REQ-004..009, load/store port.
REQ-011 i_if_req  input  1  instruction-fetch request, read-only, held until o_if_ack.
REQ-012 i_if_addr  input  ADDR_WIDTH  fetch byte address.
REQ-013 o_if_ack  output  1  one-cycle completion pulse, fetch port.
REQ-014 o_rdata  output  32  read data shared by all ports, valid only in the ack cycle.
REQ-015 o_mem_en  output  1  memory access strobe.
REQ-016 o_mem_addr  output  ADDR_WIDTH  memory address.
REQ-017 o_mem_wdata  output  32  memory write data.
REQ-018 o_mem_wr_en  output  1  memory write enable, qualified by o_mem_en.
REQ-019 o_mem_wr_mask  output  4  memory byte mask.
REQ-020 i_mem_rdata  input  32  memory read data, valid one cycle after an o_mem_en read.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; 2-bit grant register (DBG, D, IF); 1-bit last_d flag.
REQ-022 Priority: DBG always highest; between D and IF, D wins unless last_d=1 and i_if_req=1, then IF wins.
REQ-023 last_d set to 1 when D is granted, cleared to 0 when IF or DBG is granted.
REQ-024 IDLE: any req -> latch winner into grant, go ACCESS; no req -> stay IDLE, o_mem_en=0.
REQ-025 ACCESS: o_mem_en=1; o_mem_addr/wdata/wr_en/wr_mask driven combinationally from the granted port; for IF, o_mem_wr_en=0, o_mem_wr_mask=0; next state RESP.
REQ-026 RESP: ack of the granted port =1 for exactly this cycle; o_rdata=i_mem_rdata; o_mem_en=0.
REQ-027 RESP exit: arbitrate among requests excluding the port acked this cycle; winner -> ACCESS with new grant, none -> IDLE.
REQ-028 Latency: req rising in IDLE at cycle N -> o_mem_en at N+1 -> ack at N+2; back-to-back throughput one access per 2 cycles.
REQ-029 At most one ack asserted in any cycle; no ack outside RESP.
REQ-030 o_rdata SHALL be 0 outside RESP; write completions also pulse ack, o_rdata is don't-care-but-driven.
REQ-031 Request deasserted during ACCESS (protocol violation): access still completes, ack still pulsed.
REQ-032 Granted port inputs are sampled only in ACCESS; changes in IDLE/RESP have no effect on the in-flight access.

Reset
REQ-033 While rst_n=0 at a rising edge: state<=IDLE, grant<=DBG, last_d<=0.
REQ-034 While rst_n=0, o_mem_en, o_mem_wr_en and all acks SHALL be forced 0 combinationally, including reset asserted mid-ACCESS (no write commits).
REQ-035 After reset release, first arbitration occurs on the first rising edge with rst_n=1.

Verification
REQ-036 Single D write addr 0x1080 data 0xDEADBEEF mask 1111 -> o_mem_en/wr_en with those values at N+1, o_d_ack at N+2, memory word 0x1080>>2 = 0xDEADBEEF.
REQ-037 D and IF requesting continuously -> grants alternate D, IF, D, IF; one ack every 2 cycles; neither starves.
REQ-038 DBG, D, IF asserted together -> DBG acked first, then D, then IF; DBG re-request always preempts next arbitration.
REQ-039 IF read of 0x0 with memory preloaded 0x00100073 -> o_if_ack at N+2 with o_rdata=0x00100073, o_mem_wr_en=0 throughout.
REQ-040 rst_n driven low in ACCESS of a D write -> o_mem_wr_en=0 that cycle, no ack, memory unchanged, state IDLE after edge.
REQ-041 D req dropped in ACCESS -> o_d_ack still pulses once at RESP, then IDLE.

Source files
------------

// File: rtl/asrv32_mem_arbiter.sv
// Three-port memory arbiter (debug, load/store, fetch) in front of one synchronous memory.
// One access every two cycles; debug always first, load/store and fetch alternate under contention.
module asrv32_mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_dbg_req,
    input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
    input  logic [31:0]           i_dbg_wdata,
    input  logic                  i_dbg_wr_en,
    input  logic [3:0]            i_dbg_wr_mask,
    output logic                  o_dbg_ack,
    input  logic                  i_d_req,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    input  logic [31:0]           i_d_wdata,
    input  logic                  i_d_wr_en,
    input  logic [3:0]            i_d_wr_mask,
    output logic                  o_d_ack,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_ack,
    output logic [31:0]           o_rdata,
    output logic                  o_mem_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic                  o_mem_wr_en,
    output logic [3:0]            o_mem_wr_mask,
    input  logic [31:0]           i_mem_rdata
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
    typedef enum logic [1:0] {GNT_DBG = 2'd0, GNT_D = 2'd1, GNT_IF = 2'd2} grant_t;

    state_t     state_reg;
    grant_t     grant_reg;
    logic       last_d_reg;

    logic [2:0] req_vec;
    logic [2:0] req_elig;
    logic       arb_valid;
    grant_t     arb_grant;
    logic       access_active;
    logic       resp_active;
    logic       sel_wr_en;

    assign req_vec = {i_if_req, i_d_req, i_dbg_req};

    // The port acknowledged this cycle sits out the arbitration that closes its own RESP.
    always_comb begin
        req_elig = req_vec;
        if (state_reg == ST_RESP) begin
            case (grant_reg)
                GNT_D:   req_elig[1] = 1'b0;
                GNT_IF:  req_elig[2] = 1'b0;
                default: req_elig[0] = 1'b0;
            endcase
        end
    end

    always_comb begin
        arb_valid = |req_elig;
        arb_grant = GNT_DBG;
        if (req_elig[0]) begin
            arb_grant = GNT_DBG;
        end else if (req_elig[1] && !(last_d_reg && req_elig[2])) begin
            arb_grant = GNT_D;
        end else if (req_elig[2]) begin
            arb_grant = GNT_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= GNT_DBG;
            last_d_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_RESP: begin
                    if (arb_valid) begin
                        state_reg  <= ST_ACCESS;
                        grant_reg  <= arb_grant;
                        last_d_reg <= (arb_grant == GNT_D);
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_ACCESS: state_reg <= ST_RESP;
                default:   state_reg <= ST_IDLE;
            endcase
        end
    end

    // Reset gates strobes and acks directly so an access interrupted by reset never commits.
    assign access_active = rst_n && (state_reg == ST_ACCESS);
    assign resp_active   = rst_n && (state_reg == ST_RESP);

    always_comb begin
        case (grant_reg)
            GNT_D: begin
                o_mem_addr    = i_d_addr;
                o_mem_wdata   = i_d_wdata;
                sel_wr_en     = i_d_wr_en;
                o_mem_wr_mask = i_d_wr_mask;
            end
            GNT_IF: begin
                o_mem_addr    = i_if_addr;
                o_mem_wdata   = 32'd0;
                sel_wr_en     = 1'b0;
                o_mem_wr_mask = 4'd0;
            end
            default: begin
                o_mem_addr    = i_dbg_addr;
                o_mem_wdata   = i_dbg_wdata;
                sel_wr_en     = i_dbg_wr_en;
                o_mem_wr_mask = i_dbg_wr_mask;
            end
        endcase
    end

    assign o_mem_en    = access_active;
    assign o_mem_wr_en = access_active && sel_wr_en;
    assign o_dbg_ack   = resp_active && (grant_reg == GNT_DBG);
    assign o_d_ack     = resp_active && (grant_reg == GNT_D);
    assign o_if_ack    = resp_active && (grant_reg == GNT_IF);
    assign o_rdata     = resp_active ? i_mem_rdata : 32'd0;
endmodule

// File: tb/tb_asrv32_mem_arbiter.sv
// Bench for asrv32_mem_arbiter: directed scenarios plus random traffic, checked by a
// scoreboard monitor against a word-level memory model and expected service order.
module tb_asrv32_mem_arbiter;
    localparam int AW = 32;
    localparam int MEM_WORDS = 2048;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  mask;
    } txn_t;

    typedef struct {
        int port;
        int cyc;
    } ord_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dbg_req, dbg_wr_en, d_req, d_wr_en, if_req;
    logic [AW-1:0] dbg_addr, d_addr, if_addr, mem_addr;
    logic [31:0]   dbg_wdata, d_wdata, rdata, mem_wdata;
    logic [31:0]   mem_rdata = 32'd0;
    logic [3:0]    dbg_wr_mask, d_wr_mask, mem_wr_mask;
    logic          dbg_ack, d_ack, if_ack, mem_en, mem_wr_en;
    logic          load_mem;

    logic [31:0]   mem     [MEM_WORDS];
    logic [31:0]   ref_mem [MEM_WORDS];
    txn_t          exp_q   [3][$];
    ord_t          exp_ord [$];

    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    int            tmo_count = 0;
    int            tmo_seen = 0;
    int            watch_idx = -1;
    int            acc_cyc = -100;
    logic [31:0]   acc_addr, acc_wdata;
    logic          acc_we;
    logic [3:0]    acc_mask;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    asrv32_mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
        .i_dbg_wr_en(dbg_wr_en), .i_dbg_wr_mask(dbg_wr_mask), .o_dbg_ack(dbg_ack),
        .i_d_req(d_req), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .i_d_wr_en(d_wr_en), .i_d_wr_mask(d_wr_mask), .o_d_ack(d_ack),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack),
        .o_rdata(rdata), .o_mem_en(mem_en), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_wr_en(mem_wr_en), .o_mem_wr_mask(mem_wr_mask), .i_mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h00100073;
        return (32'(i) * 32'h9E3779B9) ^ 32'h0F0F1234;
    endfunction

    // Synchronous memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wr_mask[b]) mem[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= mem[mem_addr[12:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%08h, required 0x%08h", name, cyc, got, want);
        end
    endtask

    // Scoreboard monitor: every ack pops the granted port's expected transaction.
    always @(negedge clk) begin
        logic [2:0]  acks;
        int          p;
        int          idx;
        txn_t        t;
        ord_t        o;
        acks = {if_ack, d_ack, dbg_ack};
        if (load_mem) begin
            for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        end
        if (tmo_count != tmo_seen) begin
            chk("wait_bound_expired", 32'(tmo_count - tmo_seen), 32'd0);
            tmo_seen = tmo_count;
        end
        if (!rst_n) chk("reset_gating", {27'd0, acks, mem_en, mem_wr_en}, 32'd0);
        chk("one_ack_max", 32'($countones(acks) > 1), 32'd0);
        if (mem_en) begin
            acc_cyc   = cyc;
            acc_addr  = mem_addr;
            acc_wdata = mem_wdata;
            acc_we    = mem_wr_en;
            acc_mask  = mem_wr_mask;
            chk("ack_during_access", {29'd0, acks}, 32'd0);
        end
        if (acks == 3'b000) begin
            chk("rdata_zero_outside_resp", rdata, 32'd0);
        end else begin
            p = acks[0] ? 0 : (acks[1] ? 1 : 2);
            chk("ack_has_pending_req", 32'(exp_q[p].size() != 0), 32'd1);
            if (exp_q[p].size() != 0) begin
                t = exp_q[p].pop_front();
                chk("access_to_ack_latency", 32'(acc_cyc), 32'(cyc - 1));
                chk("mem_addr", acc_addr, t.addr);
                chk("mem_wr_en", {31'd0, acc_we}, {31'd0, t.we});
                chk("mem_wr_mask", {28'd0, acc_mask}, {28'd0, t.mask});
                if (p != 2) chk("mem_wdata", acc_wdata, t.wdata);
                idx = int'(t.addr[12:2]);
                if (t.we) begin
                    for (int b = 0; b < 4; b++)
                        if (t.mask[b]) ref_mem[idx][8*b +: 8] = t.wdata[8*b +: 8];
                end else begin
                    chk("read_data", rdata, ref_mem[idx]);
                end
            end
            if (exp_ord.size() != 0) begin
                o = exp_ord.pop_front();
                chk("service_order_port", 32'(p), 32'(o.port));
                if (o.cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(o.cyc));
            end
        end
        if (watch_idx >= 0) chk("memory_word", mem[watch_idx], ref_mem[watch_idx]);
    end

    function automatic txn_t rand_txn(input int p);
        txn_t t;
        t.addr  = 32'($urandom_range(0, 63)) << 2;
        t.wdata = (p == 2) ? 32'd0 : $urandom;
        t.we    = (p != 2) && ($urandom_range(0, 1) == 1);
        t.mask  = (p == 2) ? 4'd0 : 4'($urandom_range(1, 15));
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input txn_t t, input logic req);
        case (p)
            0: begin
                dbg_req = req; dbg_addr = t.addr; dbg_wdata = t.wdata;
                dbg_wr_en = t.we; dbg_wr_mask = t.mask;
            end
            1: begin
                d_req = req; d_addr = t.addr; d_wdata = t.wdata;
                d_wr_en = t.we; d_wr_mask = t.mask;
            end
            default: begin
                if_req = req; if_addr = t.addr;
            end
        endcase
    endtask

    task automatic issue(input int p, input txn_t t);
        exp_q[p].push_back(t);
        drive_port(p, t, 1'b1);
    endtask

    task automatic drop(input int p);
        case (p)
            0: dbg_req = 1'b0;
            1: d_req = 1'b0;
            default: if_req = 1'b0;
        endcase
    endtask

    task automatic expect_ack(input int p, input int c);
        ord_t o;
        o.port = p;
        o.cyc  = c;
        exp_ord.push_back(o);
    endtask

    task automatic wait_ord(input int budget);
        int n = 0;
        while (exp_ord.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_ord.size() != 0) begin
            tmo_count++;
            exp_ord.delete();
        end
    endtask

    // Issue on the ports in start, re-raise ports in reissue after each ack until total
    // D/IF/DBG transactions have been issued; optionally raise DBG once after the first ack.
    task automatic run_set(input logic [2:0] start, input logic [2:0] reissue,
                           input int total, input bit dbg_late);
        bit busy [3];
        int issued = 0;
        bit dbg_done = 1'b0;
        bit any_ack = 1'b0;
        for (int p = 0; p < 3; p++) begin
            busy[p] = start[p];
            if (start[p]) begin
                issue(p, rand_txn(p));
                issued++;
            end
        end
        for (int c = 0; c < 8 * total + 20 && (busy[0] || busy[1] || busy[2]); c++) begin
            tick();
            for (int p = 0; p < 3; p++) begin
                if (busy[p] && exp_q[p].size() == 0) begin
                    busy[p] = 1'b0;
                    any_ack = 1'b1;
                    if (reissue[p] && issued < total) begin
                        issue(p, rand_txn(p));
                        busy[p] = 1'b1;
                        issued++;
                    end else begin
                        drop(p);
                    end
                end
            end
            if (dbg_late && any_ack && !dbg_done) begin
                dbg_done = 1'b1;
                issue(0, rand_txn(0));
                busy[0] = 1'b1;
            end
        end
        if (busy[0] || busy[1] || busy[2]) tmo_count++;
        for (int p = 0; p < 3; p++) begin
            drop(p);
            exp_q[p].delete();
        end
        wait_ord(4);
    endtask

    initial begin
        txn_t t;
        bit   busy [3];
        int   waited [3];
        int   c0;
        rst_n = 1'b0;
        load_mem = 1'b1;
        t = '{addr: 32'd0, wdata: 32'd0, we: 1'b0, mask: 4'd0};
        for (int p = 0; p < 3; p++) drive_port(p, t, 1'b0);
        repeat (3) tick();
        load_mem = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Single load/store write, then its memory word is watched.
        watch_idx = 32'h1080 >> 2;
        t = '{addr: 32'h1080, wdata: 32'hDEADBEEF, we: 1'b1, mask: 4'hF};
        expect_ack(1, cyc + 2);
        issue(1, t);
        wait_ord(10);
        drop(1);
        repeat (2) tick();

        // Boot-vector fetch.
        t = '{addr: 32'h0, wdata: 32'd0, we: 1'b0, mask: 4'd0};
        expect_ack(2, cyc + 2);
        issue(2, t);
        wait_ord(10);
        drop(2);
        repeat (2) tick();

        // Load/store request withdrawn during its access still completes exactly once.
        t = '{addr: 32'h40, wdata: 32'd0, we: 1'b0, mask: 4'h3};
        expect_ack(1, cyc + 2);
        issue(1, t);
        tick();
        drop(1);
        wait_ord(10);
        repeat (4) tick();

        // last_d is set, so fetch wins a simultaneous start from IDLE.
        expect_ack(2, cyc + 2);
        expect_ack(1, cyc + 4);
        run_set(3'b110, 3'b000, 2, 1'b0);
        repeat (2) tick();

        // All three together: debug, then load/store, then fetch.
        c0 = cyc;
        expect_ack(0, c0 + 2);
        expect_ack(1, c0 + 4);
        expect_ack(2, c0 + 6);
        run_set(3'b111, 3'b000, 3, 1'b0);
        repeat (2) tick();

        // Continuous load/store and fetch alternate, one ack every two cycles.
        c0 = cyc;
        for (int i = 0; i < 8; i++) expect_ack((i % 2 == 0) ? 1 : 2, c0 + 2 + 2 * i);
        run_set(3'b110, 3'b110, 8, 1'b0);
        repeat (2) tick();

        // A debug request raised mid-stream takes the next free arbitration.
        c0 = cyc;
        expect_ack(1, c0 + 2);
        expect_ack(2, c0 + 4);
        expect_ack(0, c0 + 6);
        expect_ack(1, c0 + 8);
        expect_ack(2, c0 + 10);
        expect_ack(1, c0 + 12);
        run_set(3'b110, 3'b110, 5, 1'b1);
        repeat (2) tick();

        // Reset during the access cycle of a write: nothing commits, no ack.
        watch_idx = 32'h300 >> 2;
        t = '{addr: 32'h300, wdata: 32'hCAFEF00D, we: 1'b1, mask: 4'hF};
        issue(1, t);
        tick();
        rst_n = 1'b0;
        tick();
        exp_q[1].delete();
        t = '{addr: 32'h300, wdata: 32'd0, we: 1'b0, mask: 4'hF};
        expect_ack(1, cyc + 2);
        issue(1, t);
        rst_n = 1'b1;
        wait_ord(10);
        drop(1);
        repeat (3) tick();
        watch_idx = -1;

        // Random traffic on all three ports.
        for (int p = 0; p < 3; p++) begin
            busy[p] = 1'b0;
            waited[p] = 0;
        end
        for (int c = 0; c < 700; c++) begin
            tick();
            for (int p = 0; p < 3; p++) begin
                if (busy[p] && exp_q[p].size() == 0) begin
                    busy[p] = 1'b0;
                    drop(p);
                end else if (busy[p]) begin
                    waited[p]++;
                    if (waited[p] > 60) begin
                        tmo_count++;
                        busy[p] = 1'b0;
                        drop(p);
                        exp_q[p].delete();
                    end
                end else if (c < 500 && $urandom_range(0, 2) == 0) begin
                    issue(p, rand_txn(p));
                    busy[p] = 1'b1;
                    waited[p] = 0;
                end
            end
            if (c >= 500 && !busy[0] && !busy[1] && !busy[2]) break;
        end
        if (busy[0] || busy[1] || busy[2]) tmo_count++;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
